stack_sequencer: RTL and testbench

- Sequences the stack pointer S for all stack traffic: single-byte push/pull, JSR/RTS, BRK/IRQ/NMI entry, RTI, and the reset S-dummy sequence.
- Drives the S register's load and select controls (0 = hold/load datain, 1 = +1, 2 = −1).
- Forms the page-1 stack address from the current S value.
- Issues bus read/write strobes and steers write-source and read-destination selects.
- Sits between the instruction decoder (command source) and the S register and memory interface.

---
 rtl/stack_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_stack_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer
//   Sequences the 6502-style stack pointer S for all stack traffic: single-byte
//   push/pull, JSR/RTS, BRK/IRQ/NMI entry, RTI, and the reset S-dummy reads.
//   The block owns no copy of S. It steers the external S register through
//   s_load/s_sel, and it forms the page-1 stack address from s_value.
//
// Ports
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake with the decoder (ready only in IDLE)
//   cmd_op[2:0]           0 PUSH1, 1 PULL1, 2 PUSH2, 3 PULL2, 4 PUSH3, 5 PULL3,
//                         6 RSTSEQ, 7 illegal
//   s_value[7:0]          current S register value
//   s_load, s_sel[1:0]    S register load enable / select (0 hold, 1 +1, 2 -1)
//   mem_addr[ADDR_W-1:0]  stack address {STACK_PAGE, s_value}
//   mem_rd, mem_wr        bus strobes, held until mem_ready
//   mem_ready             bus completes the current access this cycle
//   wsel[1:0]             write source: 0 A/P byte, 1 PCH, 2 PCL, 3 P
//   rsel[1:0]             read destination: 0 A/P, 1 PCH, 2 PCL, 3 P
//   rd_capture            destination loads read data this cycle
//   busy, done, err       not-idle flag; finish pulse; illegal-op pulse with done
module stack_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [7:0]        s_value,
    output logic              s_load,
    output logic [1:0]        s_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    output logic [1:0]        wsel,
    output logic [1:0]        rsel,
    output logic              rd_capture,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_INC,
        ST_PULL,
        ST_DUMMY,
        ST_FIN
    } state_t;

    typedef enum logic [2:0] {
        OP_PUSH1   = 3'd0,
        OP_PULL1   = 3'd1,
        OP_PUSH2   = 3'd2,
        OP_PULL2   = 3'd3,
        OP_PUSH3   = 3'd4,
        OP_PULL3   = 3'd5,
        OP_RSTSEQ  = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        len_q, len_d;
    logic [1:0]        idx_nxt;
    logic              last_byte;
    logic [ADDR_W-1:0] stack_addr;

    assign idx_nxt    = idx_q + 2'd1;
    assign last_byte  = (idx_nxt == len_q);
    assign stack_addr = ADDR_W'({STACK_PAGE, s_value});
    assign busy       = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_PUSH1;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        len_d      = len_q;
        // cmd_ready is masked by rst so every output reads 0 while reset is held
        cmd_ready  = 1'b0;
        s_load     = 1'b0;
        s_sel      = 2'd0;
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        wsel       = 2'd0;
        rsel       = 2'd0;
        rd_capture = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && cmd_ready) begin
                    op_d  = op_t'(cmd_op);
                    idx_d = '0;
                    case (op_t'(cmd_op))
                        OP_PUSH1:  begin len_d = 2'd1; state_d = ST_PUSH;  end
                        OP_PULL1:  begin len_d = 2'd1; state_d = ST_INC;   end
                        OP_PUSH2:  begin len_d = 2'd2; state_d = ST_PUSH;  end
                        OP_PULL2:  begin len_d = 2'd2; state_d = ST_INC;   end
                        OP_PUSH3:  begin len_d = 2'd3; state_d = ST_PUSH;  end
                        OP_PULL3:  begin len_d = 2'd3; state_d = ST_INC;   end
                        OP_RSTSEQ: begin len_d = 2'd3; state_d = ST_DUMMY; end
                        default:   begin len_d = 2'd1; state_d = ST_FIN;   end
                    endcase
                end
            end

            ST_PUSH: begin
                mem_wr   = 1'b1;
                mem_addr = stack_addr;
                // multi-byte pushes go PCH, PCL, P: source code is idx+1
                wsel     = (op_q == OP_PUSH1) ? 2'd0 : idx_nxt;
                if (mem_ready) begin
                    s_load  = 1'b1;
                    s_sel   = 2'd2;
                    idx_d   = idx_nxt;
                    state_d = last_byte ? ST_FIN : ST_PUSH;
                end
            end

            ST_INC: begin
                s_load  = 1'b1;
                s_sel   = 2'd1;
                state_d = ST_PULL;
            end

            ST_PULL: begin
                mem_rd   = 1'b1;
                mem_addr = stack_addr;
                // pulls mirror the push order: P, PCL, PCH, i.e. len-idx
                rsel     = (op_q == OP_PULL1) ? 2'd0 : (len_q - idx_q);
                if (mem_ready) begin
                    rd_capture = 1'b1;
                    idx_d      = idx_nxt;
                    state_d    = last_byte ? ST_FIN : ST_INC;
                end
            end

            ST_DUMMY: begin
                mem_rd   = 1'b1;
                mem_addr = stack_addr;
                if (mem_ready) begin
                    s_load  = 1'b1;
                    s_sel   = 2'd2;
                    idx_d   = idx_nxt;
                    state_d = last_byte ? ST_FIN : ST_DUMMY;
                end
            end

            ST_FIN: begin
                done    = 1'b1;
                err     = (op_q == OP_ILLEGAL);
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  s_value;
    logic        s_load;
    logic [1:0]  s_sel;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;
    logic [1:0]  wsel;
    logic [1:0]  rsel;
    logic        rd_capture;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Expected bus accesses, in order.
    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [1:0]  sel;
        bit          cap;
        bit          sload;
        logic [1:0]  ssel;
    } acc_t;
    acc_t exp_q[$];

    // External S register model plus bus stall model and event counters.
    logic [7:0] s_reg;
    logic       s_preset;
    logic [7:0] s_preset_val;
    int         preset_stall;
    int         stall_at;
    int         stall_left;
    int         acc_idx;
    int         sload_cnt;
    int         accept_cnt;
    int         done_cnt;
    int         err_cnt;

    assign s_value   = s_reg;
    assign mem_ready = !(stall_left > 0 && acc_idx == stall_at && (mem_rd || mem_wr));

    stack_sequencer #(.STACK_PAGE(8'h01), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .s_value    (s_value),
        .s_load     (s_load),
        .s_sel      (s_sel),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_ready  (mem_ready),
        .wsel       (wsel),
        .rsel       (rsel),
        .rd_capture (rd_capture),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (s_preset) begin
            s_reg      <= s_preset_val;
            stall_left <= preset_stall;
            acc_idx    <= 0;
            sload_cnt  <= 0;
            accept_cnt <= 0;
            done_cnt   <= 0;
            err_cnt    <= 0;
        end else begin
            if (s_load) begin
                sload_cnt <= sload_cnt + 1;
                if (s_sel == 2'd1) s_reg <= s_reg + 8'd1;
                else if (s_sel == 2'd2) s_reg <= s_reg - 8'd1;
            end
            if (!rst && (mem_rd || mem_wr)) begin
                if (mem_ready) acc_idx <= acc_idx + 1;
                else stall_left <= stall_left - 1;
            end
            if (cmd_valid && cmd_ready) accept_cnt <= accept_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
        end
    end

    // Scoreboard: every access cycle is compared against the head of exp_q;
    // the head is popped when the bus completes it.
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
            if (mem_rd || mem_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", {30'd0, mem_rd, mem_wr}, 32'd0);
                end else begin
                    acc_t e;
                    e = exp_q[0];
                    check("acc_dir", {31'd0, mem_wr}, {31'd0, e.wr});
                    check("acc_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                    check("acc_sel", {30'd0, (mem_wr ? wsel : rsel)}, {30'd0, e.sel});
                    check("acc_capture", {31'd0, rd_capture}, {31'd0, mem_ready & e.cap});
                    check("acc_sload", {31'd0, s_load}, {31'd0, mem_ready & e.sload});
                    if (mem_ready) begin
                        if (e.sload) check("acc_ssel", {30'd0, s_sel}, {30'd0, e.ssel});
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_capture", {31'd0, rd_capture}, 32'd0);
                if (s_load) check("inc_ssel", {30'd0, s_sel}, 32'd1);
            end
        end
    end

    task automatic preset(input logic [7:0] v, input int stall_cycles, input int stall_byte);
        @(posedge clk); #1;
        s_preset     = 1'b1;
        s_preset_val = v;
        preset_stall = stall_cycles;
        stall_at     = stall_byte;
        @(posedge clk); #1;
        s_preset     = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op);
        cmd_op    = op;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    function automatic acc_t mk(input bit wr, input logic [15:0] a, input logic [1:0] sel,
                                input bit cap, input bit sl, input logic [1:0] ss);
        acc_t r;
        r.wr = wr; r.addr = a; r.sel = sel; r.cap = cap; r.sload = sl; r.ssel = ss;
        return r;
    endfunction

    initial begin
        int cyc;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 3'd0;
        s_preset     = 1'b0;
        s_preset_val = 8'h00;
        preset_stall = 0;
        stall_at     = 0;

        // Reset state
        #12;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_strobes", {29'd0, mem_rd, mem_wr, s_load}, 32'd0);
        check("rst_ssel", {30'd0, s_sel}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // PUSH1, S=FD, no stall
        preset(8'hFD, 0, 0);
        exp_q.push_back(mk(1'b1, 16'h01FD, 2'd0, 1'b0, 1'b1, 2'd2));
        issue(3'd0);
        check("push1_busy", {31'd0, busy}, 32'd1);
        wait_done("push1", cyc);
        check("push1_latency", cyc, 32'd2);
        check("push1_err", {31'd0, err}, 32'd0);
        check("push1_s", {24'd0, s_reg}, 32'h0FC);

        // PUSH3, S=02, byte 2 stalled two cycles
        preset(8'h02, 2, 1);
        exp_q.push_back(mk(1'b1, 16'h0102, 2'd1, 1'b0, 1'b1, 2'd2));
        exp_q.push_back(mk(1'b1, 16'h0101, 2'd2, 1'b0, 1'b1, 2'd2));
        exp_q.push_back(mk(1'b1, 16'h0100, 2'd3, 1'b0, 1'b1, 2'd2));
        issue(3'd4);
        wait_done("push3", cyc);
        check("push3_latency", cyc, 32'd6);
        check("push3_s", {24'd0, s_reg}, 32'h0FF);
        check("push3_sloads", sload_cnt, 32'd3);

        // PULL2, S=FE: INC, read 01FF, INC, read 0100
        preset(8'hFE, 0, 0);
        exp_q.push_back(mk(1'b0, 16'h01FF, 2'd2, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(mk(1'b0, 16'h0100, 2'd1, 1'b1, 1'b0, 2'd0));
        issue(3'd3);
        wait_done("pull2", cyc);
        check("pull2_latency", cyc, 32'd5);
        check("pull2_s", {24'd0, s_reg}, 32'h000);
        check("pull2_sloads", sload_cnt, 32'd2);

        // RSTSEQ, S=00: dummy reads 0100, 01FF, 01FE
        preset(8'h00, 0, 0);
        exp_q.push_back(mk(1'b0, 16'h0100, 2'd0, 1'b0, 1'b1, 2'd2));
        exp_q.push_back(mk(1'b0, 16'h01FF, 2'd0, 1'b0, 1'b1, 2'd2));
        exp_q.push_back(mk(1'b0, 16'h01FE, 2'd0, 1'b0, 1'b1, 2'd2));
        issue(3'd6);
        wait_done("rstseq", cyc);
        check("rstseq_latency", cyc, 32'd4);
        check("rstseq_s", {24'd0, s_reg}, 32'h0FD);

        // Illegal op
        preset(8'h40, 0, 0);
        issue(3'd7);
        wait_done("illegal", cyc);
        check("illegal_latency", cyc, 32'd1);
        check("illegal_err", {31'd0, err}, 32'd1);
        check("illegal_sloads", sload_cnt, 32'd0);
        check("illegal_s", {24'd0, s_reg}, 32'h040);

        // cmd_valid held across busy: accepted only from IDLE (every other edge)
        preset(8'h40, 0, 0);
        cmd_op    = 3'd7;
        cmd_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("hold_accepts", accept_cnt, 32'd3);
        check("hold_dones", done_cnt, 32'd3);
        check("hold_errs", err_cnt, 32'd3);

        // Reset during PULL3 after the first byte
        preset(8'h10, 0, 0);
        exp_q.push_back(mk(1'b0, 16'h0111, 2'd3, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(mk(1'b0, 16'h0112, 2'd2, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(mk(1'b0, 16'h0113, 2'd1, 1'b1, 1'b0, 2'd0));
        issue(3'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pull3_inc_sload", {31'd0, s_load}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_sload", {31'd0, s_load}, 32'd0);
        check("abort_strobes", {29'd0, mem_rd, mem_wr, rd_capture}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd0);
        check("abort_pending", exp_q.size(), 32'd2);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_s_kept", {24'd0, s_reg}, 32'h011);
        check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
